// File: rtl/dmem_responder.sv
// Data-memory responder: a single outstanding load/store with fixed access latency,
// byte-masked writes into a flop-based word array, and a registered response.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [31:0]             req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NumBytes-1:0]     be_q;
  logic                    err_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    req_err;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   commit_word;

  // Misaligned or beyond the array: flagged at capture, suppresses the write at commit.
  assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= 30'(DEPTH));

  // The commit edge is the last WAIT cycle.
  assign commit = (state_q == StWait) && (cnt_q == 4'd0);

  // Current word with store lanes merged in; for loads this is just the stored word.
  always_comb begin
    commit_word = mem_q[idx_q];
    if (we_q) begin
      for (int i = 0; i < int'(NumBytes); i++) begin
        if (be_q[i]) begin
          commit_word[8*i +: 8] = wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Ready is a pure state decode, forced low while reset is held.
  assign req_ready_o = (state_q == StIdle) && !rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            idx_q   <= req_addr_i[IdxW+1:2];
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            err_q   <= req_err;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= err_q ? '0 : commit_word;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          // Data and error are left holding their last values after the handshake.
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array update happens only at commit of an in-range, aligned store.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && we_q && !err_q) begin
      mem_q[idx_q] <= commit_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference array predicts each response,
// expectations are queued at request time and popped when rsp_valid appears.
module tb_dmem_responder;

  localparam int unsigned Latency = 2;
  localparam int unsigned Depth   = 32;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_model [Depth];
  int          n_vec;
  int          n_err;

  dmem_responder #(
    .DATA_WIDTH(32),
    .DEPTH     (Depth),
    .LATENCY   (Latency)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_we_i   (req_we),
    .req_wdata_i(req_wdata),
    .req_be_i   (req_be),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Predict the response and update the reference array, then queue the prediction.
  task automatic predict(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] be);
    exp_t        e;
    logic [31:0] w;
    if (addr[1:0] != 2'b00 || addr[31:2] >= 30'(Depth)) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else begin
      w = mem_model[addr[6:2]];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        end
        mem_model[addr[6:2]] = w;
      end
      e.rdata = w;
      e.err   = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  // One full transaction; caller is positioned away from a rising edge.
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = (stall == 0);
    predict(addr, we, wdata, be);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("req_ready_after_accept", req_ready, 1'b0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", n, Latency);
    if (exp_q.size() == 0) begin
      check_eq("sb_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_eq("rsp_rdata", rsp_rdata, e.rdata);
    check_eq("rsp_err", rsp_err, e.err);
    for (int k = 0; k < stall; k++) begin
      // A request offered mid-backpressure must be ignored.
      req_valid = (k == 2);
      req_addr  = 32'h0000_0008;
      req_we    = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_rdata", rsp_rdata, e.rdata);
      check_eq("hold_err", rsp_err, e.err);
      check_eq("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", rsp_valid, 1'b0);
    check_eq("req_ready_return", req_ready, 1'b1);
    check_eq("rdata_kept", rsp_rdata, e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    foreach (mem_model[i]) mem_model[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_req_ready", req_ready, 1'b0);
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("reset_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_req(32'h08, 1'b0, 32'h0, 4'hF, 0);
    do_req(32'h10, 1'b1, 32'hDEADBEEF, 4'b1111, 0);
    do_req(32'h10, 1'b0, 32'h0, 4'hF, 0);
    do_req(32'h10, 1'b1, 32'h11223344, 4'b0101, 0);
    do_req(32'h10, 1'b0, 32'h0, 4'b0000, 0);
    do_req(32'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, 0);
    do_req(32'h12, 1'b0, 32'h0, 4'hF, 0);
    do_req(32'h80, 1'b0, 32'h0, 4'hF, 0);
    do_req(32'h10, 1'b0, 32'h0, 4'hF, 5);

    // Fill every word, attempt an out-of-range store, then read everything back.
    for (int i = 0; i < int'(Depth); i++) begin
      do_req(32'(i * 4), 1'b1, 32'hA5000000 ^ (32'(i) * 32'h00010203), 4'hF, 0);
    end
    do_req(32'h80, 1'b1, 32'hFFFFFFFF, 4'hF, 0);
    for (int i = 0; i < int'(Depth); i++) begin
      do_req(32'(i * 4), 1'b0, 32'h0, 4'hF, 0);
    end

    // Store to 0x04 interrupted by reset while waiting.
    req_valid = 1'b1;
    req_addr  = 32'h04;
    req_we    = 1'b1;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rst_store_accepted", req_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_req_ready", req_ready, 1'b0);
    check_eq("async_rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("async_rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("async_rst_rsp_err", rsp_err, 1'b0);
    foreach (mem_model[i]) mem_model[i] = 32'h0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h04, 1'b0, 32'h0, 4'hF, 0);
    do_req(32'h10, 1'b0, 32'h0, 4'hF, 0);

    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake, models a fixed access latency, and performs byte-masked writes into an internal word array. It returns read data and an error flag over a second valid/ready handshake. This block lets the memory stage run against a realistic multi-cycle memory and exercise pipeline stalls, instead of a zero-latency array.

Parameters:
DATA_WIDTH, 32, data word width in bits (fixed at 32; byte-enable width is DATA_WIDTH/8).
DEPTH, 32, number of words in the array; word index = req_addr[31:2].
LATENCY, 2, number of cycles from request acceptance to the first cycle of rsp_valid; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address
req_we  input  1  1 = store, 0 = load
req_wdata  input  32  store data, lane-aligned
req_be  input  4  byte enables for stores; bit i selects bits [8i+7:8i]
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  load data, or post-write word for stores
rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; rsp_valid=0; rsp_rdata=0; rsp_err=0; all array words=0; latency counter=0. req_ready=0 while rst is high.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at an edge: capture addr, we, wdata and be; load counter=LATENCY-1; go to WAIT.
  - Error check at capture: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
- WAIT:
  - req_ready=0; request inputs are ignored.
  - Each edge: if counter==0, commit and go to RESP; else counter decrements.
- Commit (on the WAIT->RESP edge only):
  - Load, no error: rsp_rdata = mem[idx].
  - Store, no error: for each lane with be[i]=1, mem[idx] lane i is updated. rsp_rdata = the merged, post-write word.
  - Error: no array write; rsp_rdata=0; rsp_err=1. Otherwise rsp_err=0.
  - rsp_valid is set to 1.
- Latency: a request accepted at edge E0 gives rsp_valid=1 immediately after edge E(LATENCY).
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid goes to 0 and state goes to IDLE. rsp_rdata and rsp_err keep their last values.
  - The earliest next acceptance is the edge after the return to IDLE, so there is one idle cycle between transactions.
- A store with be=4'b0000 is legal: the array is unchanged and the response returns the current word.
- Loads ignore req_be and always return the full word.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation:
  - Asserting rst in WAIT drops the request with no array write.
  - Asserting rst in RESP drops the pending response.
  - All outputs take their reset values immediately (asynchronous).
- The array is written only at commit. There is no combinational path from any req_* input to any rsp_* output. req_ready is decoded from state only.

Test Plan:
- Reset, then load addr 0x08 with LATENCY=2, rsp_ready=1: accept at E0, rsp_valid=1 after E2, rsp_rdata=0x00000000, rsp_err=0; req_ready returns to 1 one cycle later.
- Store addr 0x10, wdata=0xDEADBEEF, be=4'b1111, then load 0x10: the store response returns rdata=0xDEADBEEF, and the load returns 0xDEADBEEF.
- Store addr 0x10, wdata=0x11223344, be=4'b0101 over 0xDEADBEEF: response rdata=0xDE22BE44, and a later load returns 0xDE22BE44.
- Load addr 0x12 (misaligned) and load addr 0x80 (index 32 >= DEPTH): each gives rsp_err=1 and rsp_rdata=0. A store to 0x80 leaves all 32 words unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_rdata and rsp_err stay constant, req_ready=0, and a req_valid pulse during this time is not accepted. Releasing rsp_ready completes the transaction.
- Store to 0x04 with rst pulsed during WAIT: all outputs reset asynchronously, a later load of 0x04 returns 0x00000000, and the FSM accepts a new request the first edge after rst falls.
